// File: rtl/vx_commit_gather_pkg.sv
// Shared commit-side types and sizing helpers for the lane-sliced
// writeback path, reused by the serializer and the gather block.
package vx_commit_gather_pkg;

    localparam int DEF_NUM_THREADS = 4;
    localparam int DEF_NUM_LANES   = 2;
    localparam int DEF_NUM_WARPS   = 4;
    localparam int DEF_XLEN        = 32;
    localparam int DEF_NR_BITS     = 6;
    localparam int DEF_UUID_WIDTH  = 44;

    // Width of an index over n items, never below one bit.
    function automatic int up_clog2(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int DEF_NW_WIDTH  = up_clog2(DEF_NUM_WARPS);
    localparam int DEF_NUM_PIDS  = DEF_NUM_THREADS / DEF_NUM_LANES;
    localparam int DEF_PID_WIDTH = up_clog2(DEF_NUM_PIDS);

    typedef struct packed {
        logic [DEF_UUID_WIDTH-1:0] uuid;
        logic [DEF_NW_WIDTH-1:0]   wid;
        logic [DEF_XLEN-1:0]       PC;
        logic [DEF_NR_BITS-1:0]    rd;
        logic                      wb;
    } commit_hdr_t;

    typedef enum logic [1:0] {
        GS_IDLE   = 2'd0,
        GS_GATHER = 2'd1,
        GS_FULL   = 2'd2
    } gather_state_e;

endpackage

// File: rtl/vx_commit_gather_buf.sv
// Gather buffer: full-width data and tmask registers with a
// pid-addressed slice-write port and a mask clear for new records.
module vx_commit_gather_buf
    import vx_commit_gather_pkg::*;
#(
    parameter int NUM_THREADS = DEF_NUM_THREADS,
    parameter int NUM_LANES   = DEF_NUM_LANES,
    parameter int XLEN        = DEF_XLEN,
    parameter int PID_WIDTH   = DEF_PID_WIDTH
) (
    input  logic                        clk_i,
    input  logic                        reset_i,
    input  logic                        clr_i,
    input  logic                        wr_i,
    input  logic [PID_WIDTH-1:0]        pid_i,
    input  logic [NUM_LANES-1:0]        tmask_i,
    input  logic [NUM_LANES*XLEN-1:0]   data_i,
    output logic [NUM_THREADS-1:0]      tmask_o,
    output logic [NUM_THREADS*XLEN-1:0] data_o
);

    localparam int NUM_PIDS = NUM_THREADS / NUM_LANES;
    localparam int SLW      = NUM_LANES * XLEN;

    logic [NUM_THREADS-1:0]      tmask_q, tmask_d;
    logic [NUM_THREADS*XLEN-1:0] data_q, data_d;

    always_comb begin
        tmask_d = clr_i ? '0 : tmask_q;
        data_d  = data_q;
        for (int p = 0; p < NUM_PIDS; p++) begin
            if (wr_i && (int'(pid_i) == p)) begin
                tmask_d[p*NUM_LANES +: NUM_LANES] = tmask_i;
                data_d[p*SLW +: SLW]              = data_i;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            tmask_q <= '0;
            data_q  <= '0;
        end else begin
            tmask_q <= tmask_d;
            data_q  <= data_d;
        end
    end

    assign tmask_o = tmask_q;
    assign data_o  = data_q;

endmodule

// File: rtl/vx_commit_gather.sv
// Reassembles lane-sliced commit beats into one full-warp writeback
// record, with a single gather buffer and sticky sequence-error flag.
module vx_commit_gather
    import vx_commit_gather_pkg::*;
#(
    parameter int NUM_THREADS  = DEF_NUM_THREADS,
    parameter int NUM_LANES    = DEF_NUM_LANES,
    parameter int NUM_WARPS    = DEF_NUM_WARPS,
    parameter int XLEN         = DEF_XLEN,
    parameter int NR_BITS      = DEF_NR_BITS,
    parameter int UUID_WIDTH   = DEF_UUID_WIDTH,
    localparam int NW_WIDTH    = up_clog2(NUM_WARPS),
    localparam int NUM_PIDS    = NUM_THREADS / NUM_LANES,
    localparam int PID_WIDTH   = up_clog2(NUM_PIDS)
) (
    input  logic                        clk,
    input  logic                        reset,

    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [UUID_WIDTH-1:0]       in_uuid,
    input  logic [NW_WIDTH-1:0]         in_wid,
    input  logic [XLEN-1:0]             in_PC,
    input  logic [NR_BITS-1:0]          in_rd,
    input  logic                        in_wb,
    input  logic [NUM_LANES-1:0]        in_tmask,
    input  logic [NUM_LANES*XLEN-1:0]   in_data,
    input  logic [PID_WIDTH-1:0]        in_pid,
    input  logic                        in_sop,
    input  logic                        in_eop,

    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [UUID_WIDTH-1:0]       out_uuid,
    output logic [NW_WIDTH-1:0]         out_wid,
    output logic [XLEN-1:0]             out_PC,
    output logic [NR_BITS-1:0]          out_rd,
    output logic                        out_wb,
    output logic [NUM_THREADS-1:0]      out_tmask,
    output logic [NUM_THREADS*XLEN-1:0] out_data,

    output logic                        err_seq
);

    gather_state_e state_q, state_d, base_st;

    logic                  err_q, err_d;
    logic [UUID_WIDTH-1:0] uuid_q;
    logic [NW_WIDTH-1:0]   wid_q;
    logic [XLEN-1:0]       pc_q;
    logic [NR_BITS-1:0]    rd_q;
    logic                  wb_q;

    logic accept, out_fire, pid_bad, wid_bad;
    logic start, wr;

    always_comb begin
        in_ready = reset & ((state_q != GS_FULL) | out_ready);
        out_fire = (state_q == GS_FULL) & out_ready;
        accept   = in_valid & in_ready;
        // A beat accepted alongside a retiring record sees an empty buffer.
        base_st  = out_fire ? GS_IDLE : state_q;
        pid_bad  = int'(in_pid) >= NUM_PIDS;
        wid_bad  = in_wid != wid_q;

        state_d = base_st;
        err_d   = err_q;
        start   = 1'b0;
        wr      = 1'b0;

        if (accept) begin
            if (pid_bad) begin
                err_d = 1'b1;
            end else if (in_sop) begin
                start = 1'b1;
                wr    = 1'b1;
                if (base_st == GS_GATHER) err_d = 1'b1;
            end else if (base_st != GS_GATHER) begin
                err_d = 1'b1;
            end else if (wid_bad) begin
                err_d = 1'b1;
            end else begin
                wr = 1'b1;
            end
            if (wr) state_d = in_eop ? GS_FULL : GS_GATHER;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= GS_IDLE;
            err_q   <= 1'b0;
            uuid_q  <= '0;
            wid_q   <= '0;
            pc_q    <= '0;
            rd_q    <= '0;
            wb_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            err_q   <= err_d;
            if (start) begin
                uuid_q <= in_uuid;
                wid_q  <= in_wid;
                pc_q   <= in_PC;
                rd_q   <= in_rd;
                wb_q   <= in_wb;
            end
        end
    end

    vx_commit_gather_buf #(
        .NUM_THREADS (NUM_THREADS),
        .NUM_LANES   (NUM_LANES),
        .XLEN        (XLEN),
        .PID_WIDTH   (PID_WIDTH)
    ) u_buf (
        .clk_i   (clk),
        .reset_i (reset),
        .clr_i   (start),
        .wr_i    (wr),
        .pid_i   (in_pid),
        .tmask_i (in_tmask),
        .data_i  (in_data),
        .tmask_o (out_tmask),
        .data_o  (out_data)
    );

    assign out_valid = (state_q == GS_FULL);
    assign out_uuid  = uuid_q;
    assign out_wid   = wid_q;
    assign out_PC    = pc_q;
    assign out_rd    = rd_q;
    assign out_wb    = wb_q;
    assign err_seq   = err_q;

endmodule
